// File: rtl/pair_detect_pkg.sv
// Shared encodings for the time-multiplexed 00/11 pair detector.
package pair_detect_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_A = 3'b000;
    localparam logic [2:0] ST_B = 3'b001;
    localparam logic [2:0] ST_C = 3'b011;
    localparam logic [2:0] ST_D = 3'b100;
    localparam logic [2:0] ST_E = 3'b101;

    function automatic int ch_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pair_detect_core.sv
// Combinational next-state / Moore output of the 00/11 pair detector.
// state | meaning
// A 000 | idle, no history
// B 001 | last bit 0, no pair
// C 011 | last bit 1, no pair
// D 100 | "00" seen (z=1)
// E 101 | "11" seen (z=1)
module pair_detect_core
    import pair_detect_pkg::*;
(
    input  state_t i_state,
    input  logic   i_w,
    output state_t o_next_state,
    output logic   o_z
);

    always_comb begin
        o_next_state = ST_A;
        case (i_state)
            ST_A:       o_next_state = i_w ? ST_C : ST_B;
            ST_B, ST_D: o_next_state = i_w ? ST_C : ST_D;
            ST_C, ST_E: o_next_state = i_w ? ST_E : ST_B;
            default:    o_next_state = ST_A;
        endcase
        o_z = (o_next_state == ST_D) || (o_next_state == ST_E);
    end

endmodule

// File: rtl/pair_detect_scheduler.sv
// Round-robin scheduler sharing one pair detector across N_CH serial streams,
// with per-channel saved context and a single tagged result port.
module pair_detect_scheduler
    import pair_detect_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8,
    localparam int CH_W = ch_w(N_CH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  in_valid,
    input  logic [N_CH-1:0]  in_bit,
    output logic [N_CH-1:0]  in_ready,
    input  logic [N_CH-1:0]  ch_clear,
    input  logic             cnt_clr,
    output logic             out_valid,
    output logic [CH_W-1:0]  out_ch,
    output logic [2:0]       out_state,
    output logic             out_z,
    output logic [CNT_W-1:0] match_cnt
);

    state_t           r_ctx [N_CH];
    logic [CH_W-1:0]  r_ptr;
    logic             r_out_valid;
    logic [CH_W-1:0]  r_out_ch;
    state_t           r_out_state;
    logic             r_out_z;
    logic [CNT_W-1:0] r_cnt;

    logic [N_CH-1:0]  w_elig;
    logic [N_CH-1:0]  w_grant;
    logic             w_found;
    logic [CH_W-1:0]  w_gidx;
    state_t           w_next;
    logic             w_z;

    // A clearing channel is never eligible, so clear and grant never collide.
    assign w_elig = in_valid & ~ch_clear & {N_CH{reset}};

    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_grant = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (!w_found && w_elig[(int'(r_ptr) + k) % N_CH]) begin
                w_found = 1'b1;
                w_gidx  = CH_W'((int'(r_ptr) + k) % N_CH);
                w_grant[(int'(r_ptr) + k) % N_CH] = 1'b1;
            end
        end
    end

    assign in_ready = w_grant;

    pair_detect_core u_core (
        .i_state      (r_ctx[w_gidx]),
        .i_w          (in_bit[w_gidx]),
        .o_next_state (w_next),
        .o_z          (w_z)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) r_ctx[i] <= ST_A;
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_state <= ST_A;
            r_out_z     <= 1'b0;
            r_cnt       <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (ch_clear[i]) r_ctx[i] <= ST_A;
            end
            r_out_valid <= w_found;
            if (w_found) begin
                r_ctx[w_gidx] <= w_next;
                r_ptr         <= (w_gidx == CH_W'(N_CH - 1)) ? '0 : w_gidx + 1'b1;
                r_out_ch      <= w_gidx;
                r_out_state   <= w_next;
                r_out_z       <= w_z;
            end
            if (cnt_clr)
                r_cnt <= '0;
            else if (w_found && w_z && (r_cnt != {CNT_W{1'b1}}))
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign out_state = r_out_state;
    assign out_z     = r_out_z;
    assign match_cnt = r_cnt;

endmodule

// File: tb/tb_pair_detect_scheduler.sv
// Bench for pair_detect_scheduler: history-based reference model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_pair_detect_scheduler;

    localparam logic [2:0] SA = 3'b000, SB = 3'b001, SC = 3'b011, SD = 3'b100, SE = 3'b101;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] in_valid, in_bit, ch_clear;
    logic       cnt_clr;

    logic [3:0] in_ready, in_ready2;
    logic       out_valid, out_valid2;
    logic [1:0] out_ch, out_ch2;
    logic [2:0] out_state, out_state2;
    logic       out_z, out_z2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;

    pair_detect_scheduler #(.N_CH(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready), .ch_clear(ch_clear), .cnt_clr(cnt_clr),
        .out_valid(out_valid), .out_ch(out_ch), .out_state(out_state),
        .out_z(out_z), .match_cnt(match_cnt)
    );

    pair_detect_scheduler #(.N_CH(4), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready2), .ch_clear(ch_clear), .cnt_clr(cnt_clr),
        .out_valid(out_valid2), .out_ch(out_ch2), .out_state(out_state2),
        .out_z(out_z2), .match_cnt(match_cnt2)
    );

    int checks = 0;
    int failures = 0;

    // Model: each channel remembers whether it has seen a bit and what the last bit was.
    bit         hv [4];
    bit         hl [4];
    int         ptr;
    bit         mv;
    int         mch;
    logic [2:0] mst;
    bit         mz;
    int         cnt8, cnt2;
    bit         model_ok = 1'b0;
    logic [3:0] last_ready;

    bit         t2_b0 [3] = '{1'b0, 1'b1, 1'b0};
    bit         t2_b1 [2] = '{1'b1, 1'b1};
    int         t2_ch [5] = '{0, 1, 0, 1, 0};
    logic [2:0] t2_st [5] = '{SB, SC, SC, SE, SB};
    int         t5_cnt [5] = '{0, 1, 2, 3, 3};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [3:0] v, input logic [3:0] b, input logic [3:0] clr,
                        input logic cc, input logic rst);
        int         g;
        logic [3:0] elig, exp_ready;
        logic [2:0] ns;
        bit         nz;
        in_valid = v; in_bit = b; ch_clear = clr; cnt_clr = cc; reset = rst;
        #1;
        elig = v & ~clr & {4{rst}};
        g = -1;
        exp_ready = 4'b0000;
        for (int k = 0; k < 4; k++)
            if (g < 0 && elig[(ptr + k) % 4]) g = (ptr + k) % 4;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("in_ready", int'(in_ready), int'(exp_ready));
        chk("in_ready_cw2", int'(in_ready2), int'(exp_ready));
        last_ready = in_ready;
        if (model_ok) begin
            chk("out_valid", int'(out_valid), int'(mv));
            chk("out_ch", int'(out_ch), mch);
            chk("out_state", int'(out_state), int'(mst));
            chk("out_z", int'(out_z), int'(mz));
            chk("match_cnt", int'(match_cnt), cnt8);
            chk("out_state_cw2", int'(out_state2), int'(mst));
            chk("match_cnt_cw2", int'(match_cnt2), cnt2);
        end
        ns = SA;
        nz = 1'b0;
        if (!rst) begin
            for (int i = 0; i < 4; i++) hv[i] = 1'b0;
            ptr = 0; mv = 1'b0; mch = 0; mst = SA; mz = 1'b0; cnt8 = 0; cnt2 = 0;
            model_ok = 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) if (clr[i]) hv[i] = 1'b0;
            if (g >= 0) begin
                if (hv[g] && hl[g] == b[g]) begin ns = b[g] ? SE : SD; nz = 1'b1; end
                else                        begin ns = b[g] ? SC : SB; nz = 1'b0; end
                hv[g] = 1'b1; hl[g] = b[g];
                mv = 1'b1; mch = g; mst = ns; mz = nz; ptr = (g + 1) % 4;
            end else begin
                mv = 1'b0;
            end
            if (cc) begin
                cnt8 = 0; cnt2 = 0;
            end else if (g >= 0 && nz) begin
                if (cnt8 < 255) cnt8++;
                if (cnt2 < 3) cnt2++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int i0, i1;
        logic [3:0] v, b;

        step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_state", int'(out_state), int'(SA));
        chk("reset_cnt", int'(match_cnt), 0);

        // ch0 alone: 0,0,1 -> B,D,C
        step(4'b0001, 4'b0000, 4'h0, 1'b0, 1'b1);
        chk("t1_state0", int'(out_state), int'(SB));
        chk("t1_z0", int'(out_z), 0);
        step(4'b0001, 4'b0000, 4'h0, 1'b0, 1'b1);
        chk("t1_state1", int'(out_state), int'(SD));
        chk("t1_z1", int'(out_z), 1);
        step(4'b0001, 4'b0001, 4'h0, 1'b0, 1'b1);
        chk("t1_state2", int'(out_state), int'(SC));
        chk("t1_z2", int'(out_z), 0);
        chk("t1_ch", int'(out_ch), 0);
        chk("t1_cnt", int'(match_cnt), 1);

        // ch0 (0,1,0) and ch1 (1,1) contending
        step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        i0 = 0; i1 = 0;
        for (int k = 0; k < 5; k++) begin
            v = {2'b00, (i1 < 2), (i0 < 3)};
            b = {2'b00, t2_b1[(i1 < 2) ? i1 : 0], t2_b0[(i0 < 3) ? i0 : 0]};
            step(v, b, 4'h0, 1'b0, 1'b1);
            if (last_ready[0]) i0++;
            if (last_ready[1]) i1++;
            chk("t2_ch", int'(out_ch), t2_ch[k]);
            chk("t2_state", int'(out_state), int'(t2_st[k]));
        end

        // all channels requesting: strict rotation
        step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(4'hF, 4'($urandom), 4'h0, 1'b0, 1'b1);
            chk("t3_ready", int'(last_ready), 1 << (k % 4));
            chk("t3_valid", int'(out_valid), 1);
        end

        // ch_clear on ch2 while pointer sits at 2
        step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        step(4'b0100, 4'b0100, 4'h0, 1'b0, 1'b1);
        step(4'b1000, 4'b0000, 4'h0, 1'b0, 1'b1);
        step(4'b0001, 4'b0000, 4'h0, 1'b0, 1'b1);
        step(4'b0010, 4'b0000, 4'h0, 1'b0, 1'b1);
        step(4'b1100, 4'b0100, 4'b0100, 1'b0, 1'b1);
        chk("t4_ready", int'(last_ready), 4'b1000);
        step(4'b0100, 4'b0100, 4'h0, 1'b0, 1'b1);
        chk("t4_ready2", int'(last_ready), 4'b0100);
        chk("t4_state", int'(out_state), int'(SC));
        chk("t4_z", int'(out_z), 0);

        // narrow counter saturation, then clear beats increment
        step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(4'b0001, 4'b0000, 4'h0, 1'b0, 1'b1);
            chk("t5_cnt", int'(match_cnt2), t5_cnt[k]);
        end
        step(4'b0001, 4'b0000, 4'h0, 1'b1, 1'b1);
        chk("t5_clr_z", int'(out_z), 1);
        chk("t5_clr_cnt2", int'(match_cnt2), 0);
        chk("t5_clr_cnt8", int'(match_cnt), 0);

        // reset mid-stream with ch0 in D
        step(4'b0001, 4'b0000, 4'h0, 1'b0, 1'b1);
        chk("t6_pre", int'(out_state), int'(SD));
        step(4'b0001, 4'b0000, 4'h0, 1'b0, 1'b0);
        chk("t6_ready", int'(last_ready), 0);
        chk("t6_valid", int'(out_valid), 0);
        chk("t6_state", int'(out_state), int'(SA));
        chk("t6_cnt", int'(match_cnt), 0);
        step(4'b0001, 4'b0000, 4'h0, 1'b0, 1'b1);
        chk("t6_after", int'(out_state), int'(SB));
        chk("t6_after_z", int'(out_z), 0);

        for (int k = 0; k < 600; k++) begin
            step(4'($urandom), 4'($urandom),
                 ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0,
                 ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 99) != 0));
        end
        step(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
